uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between NUM_REQ independent requesters, such as debounced push-button one-shot pulses or other single-cycle event strobes.
- Each pulse latches a byte into a per-requester holding register and sets a pending flag.
- A round-robin scheduler grants pending requests one at a time and drives the transmitter's start/busy handshake.
- Sits between the button/one-shot front end and the UART TX core.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ pulse-driven requesters.
// Optional build macro UART_ARB_TIMEOUT_EN adds a tx_busy acknowledge timeout in WAIT_BUSY.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_pulse,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overrun,
  output logic                       timeout
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and ACK_TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic [ID_W-1:0]     sel;
  logic                sel_vld;
  logic [SUM_W-1:0]    rr_idx;
  logic [DATA_W-1:0]   hold [NUM_REQ];
  logic                tx_start_d;
  logic [DATA_W-1:0]   tx_data_d;
  logic [ID_W-1:0]     grant_d;
  logic [NUM_REQ-1:0]  pending_d, overrun_d, grant_clr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             timeout_d;
`endif

  // First pending requester at or after ptr, wrapping around
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    rr_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, ptr} + SUM_W'(k);
      if (rr_idx >= SUM_W'(NUM_REQ)) begin
        rr_idx = rr_idx - SUM_W'(NUM_REQ);
      end
      if (!sel_vld && pending[rr_idx[ID_W-1:0]]) begin
        sel     = rr_idx[ID_W-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    grant_d    = grant_id;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    grant_clr  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt;
    timeout_d  = timeout;
`endif

    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_d        = START;
          tx_start_d     = 1'b1;
          grant_d        = sel;
          tx_data_d      = hold[sel];
          grant_clr[sel] = 1'b1;
          ptr_d          = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
        end
      end
      START: begin
        state_d = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop this grant and move on
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pulse in the grant cycle re-arms the request instead of counting as overrun
    overrun_d = overrun | (req_pulse & pending & ~grant_clr);
    pending_d = (pending & ~grant_clr) | req_pulse;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      grant_id <= grant_d;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
      pending  <= pending_d;
      overrun  <= overrun_d;
    end
  end

  // Per-requester holding registers, last pulse wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_pulse[i]) begin
          hold[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model on tx_start/tx_busy.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_pulse;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      tx_busy;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic [ID_W-1:0]           grant_id;
  logic [NUM_REQ-1:0]        pending;
  logic [NUM_REQ-1:0]        overrun;
  logic                      timeout;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   start_cnt[NUM_REQ];
  int   cyc = 0;
  int   last_start_cyc = 0;
  int   prev_start_cyc = 0;
  logic model_en = 1'b1;
  int   busy_len = 10;
  logic model_active = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .req_data(req_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id), .pending(pending),
    .overrun(overrun), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every tx_start pops the scoreboard
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        checks++;
        if (prev !== 1'b0) begin
          errors++;
          $display("FAIL start_width: tx_start high in consecutive cycles at cycle %0d", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: id=%0d data=%h, none expected", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            errors++;
            $display("FAIL grant: got id=%0d data=%h, expected id=%0d data=%h",
                     grant_id, tx_data, e.id, e.data);
          end
        end
        start_cnt[grant_id]++;
        prev_start_cyc = last_start_cyc;
        last_start_cyc = cyc;
      end
      prev = tx_start;
    end
  end

  // Transmitter model: busy from the cycle after tx_start, for busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1 && model_en) begin
        model_active = 1'b1;
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_pulse = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(NUM_REQ); i++) start_cnt[i] = 0;
    tick();
  endtask

  task automatic pulse(input logic [NUM_REQ-1:0] m, input logic [NUM_REQ*DATA_W-1:0] d);
    req_pulse = m;
    req_data  = d;
    tick();
    req_pulse = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || model_active || tx_busy || pending != '0 || tx_start) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: %0d expectations still queued, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_busy: tx_busy=%b, required 1 within 50 cycles", tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL rst_overrun: got %b want 0000", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    busy_len = 10;
    exp_q.push_back({2'd1, 8'h41});
    pulse(4'b0010, 32'h0000_4100);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL single_pending_c1: got %b want 0010", pending); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_c1: got %b want 0", tx_start); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_c2: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'h41 || grant_id !== 2'd1) begin
      errors++; $display("FAIL single_data_c2: got %h/%0d want 41/1", tx_data, grant_id);
    end
    drain();
    checks++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin
      errors++; $display("FAIL single_final: pending=%b overrun=%b want 0000/0000", pending, overrun);
    end
    checks++; if (start_cnt[1] != 1) begin errors++; $display("FAIL single_count: got %0d want 1", start_cnt[1]); end
  endtask

  task automatic test_fairness();
    do_reset();
    busy_len = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 8'(8'h10 + i)});
    pulse(4'b1111, 32'h1312_1110);
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (start_cnt[i] != 1) begin errors++; $display("FAIL fair_count%0d: got %0d want 1", i, start_cnt[i]); end
    end
    exp_q.push_back({2'd0, 8'h20});
    exp_q.push_back({2'd3, 8'h23});
    pulse(4'b1001, 32'h2300_0020);
    drain();
    checks++; if (start_cnt[0] != 2 || start_cnt[3] != 2) begin
      errors++; $display("FAIL fair_wrap: got %0d/%0d want 2/2", start_cnt[0], start_cnt[3]);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    busy_len = 20;
    exp_q.push_back({2'd0, 8'h01});
    pulse(4'b0101, 32'h00AA_0001);
    wait_busy();
    exp_q.push_back({2'd2, 8'hBB});
    pulse(4'b0100, 32'h00BB_0000);
    checks++; if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_flag: got %b want 0100", overrun); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ovr_pending: got %b want 0100", pending); end
    drain();
    checks++; if (start_cnt[2] != 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", start_cnt[2]); end
    checks++; if (overrun !== 4'b0100) begin errors++; $display("FAIL ovr_sticky: got %b want 0100", overrun); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    busy_len = 4;
    exp_q.push_back({2'd1, 8'h33});
    exp_q.push_back({2'd1, 8'h55});
    pulse(4'b0010, 32'h0000_3300);
    pulse(4'b0010, 32'h0000_5500);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h33) begin
      errors++; $display("FAIL same_old_byte: start=%b data=%h want 1/33", tx_start, tx_data);
    end
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL same_pending: got %b want 0010", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL same_overrun: got %b want 0000", overrun); end
    drain();
    checks++; if (start_cnt[1] != 2) begin errors++; $display("FAIL same_count: got %0d want 2", start_cnt[1]); end
  endtask

  task automatic test_reset_mid();
    int total;
    do_reset();
    busy_len = 20;
    exp_q.push_back({2'd0, 8'h77});
    pulse(4'b0001, 32'h0000_0077);
    wait_busy();
    tick();
    tick();
    pulse(4'b1000, 32'h9900_0000);
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL mid_pending: got %b want 1000", pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
      errors++; $display("FAIL mid_async_data: got %h/%0d want 00/0", tx_data, grant_id);
    end
    checks++; if (pending !== 4'b0000 || overrun !== 4'b0000 || tx_start !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL mid_async_flags: pending=%b overrun=%b start=%b timeout=%b want all 0",
                         pending, overrun, tx_start, timeout);
    end
    @(posedge clk); #1 rst = 1'b0;
    total = start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3];
    repeat (40) tick();
    checks++; if (start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3] != total) begin
      errors++; $display("FAIL mid_no_start: start count changed after reset, want %0d", total);
    end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mid_pending_after: got %b want 0000", pending); end
    drain();
  endtask

  task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
    int n;
    do_reset();
    model_en = 1'b0;
    exp_q.push_back({2'd0, 8'h5A});
    exp_q.push_back({2'd1, 8'h5B});
    pulse(4'b0011, 32'h0000_5B5A);
    n = 0;
    while (start_cnt[1] == 0 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (last_start_cyc - prev_start_cyc != 17) begin
      errors++; $display("FAIL to_gap: got %0d cycles between starts want 17", last_start_cyc - prev_start_cyc);
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL to_pending: got %b want 0000", pending); end
    repeat (20) tick();
    model_en = 1'b1;
    drain();
    do_reset();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout); end
`else
    busy_len = 2;
    exp_q.push_back({2'd2, 8'hC3});
    pulse(4'b0100, 32'h00C3_0000);
    drain();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_tied: got %b want 0", timeout); end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    req_pulse = '0;
    req_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) start_cnt[i] = 0;
    test_reset();
    test_single();
    test_fairness();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unserved, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
